// File: rtl/button_press_classifier_pkg.sv
// Shared types for the button press classifier: FSM state encoding and the
// event codes used by benches and by any future encoded-event output.
package button_press_classifier_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_LONG   = 3'd2,
        ST_GAP    = 3'd3,
        ST_PRESS2 = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        EVT_NONE  = 3'd0,
        EVT_SHORT = 3'd1,
        EVT_LONG  = 3'd2,
        EVT_REP   = 3'd3,
        EVT_DBL   = 3'd4
    } evt_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_press_classifier.sv
// Classifies debounced button gestures into short / long (+auto-repeat) / double
// presses and emits one-cycle registered event pulses.
module button_press_classifier
    import button_press_classifier_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned LONG_CNT   = 1000,
    parameter int unsigned REPEAT_CNT = 250,
    parameter int unsigned GAP_CNT    = 300
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic btn_in,
    output logic short_p,
    output logic long_p,
    output logic rep_p,
    output logic dbl_p,
    output logic busy
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CNT - 1);

    if (LONG_CNT < 2 || REPEAT_CNT < 2 || GAP_CNT < 2) begin : g_bad_thresholds
        $error("button_press_classifier: LONG_CNT, REPEAT_CNT and GAP_CNT must be >= 2");
    end
    if (CNT_W >= 32 ? 1'b0
                    : (max3(LONG_CNT, REPEAT_CNT, GAP_CNT) - 1) >= (32'd1 << CNT_W)) begin : g_bad_width
        $error("button_press_classifier: CNT_W too narrow for the largest threshold");
    end

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    evt_t             evt_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        evt_nxt   = EVT_NONE;
        if (!en) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (btn_in) begin
                        state_nxt = ST_PRESS1;
                        cnt_nxt   = '0;
                    end
                end
                ST_PRESS1: begin
                    if (!btn_in) begin
                        state_nxt = ST_GAP;
                        cnt_nxt   = '0;
                    end else if (cnt == LONG_LAST) begin
                        state_nxt = ST_LONG;
                        cnt_nxt   = '0;
                        evt_nxt   = EVT_LONG;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_LONG: begin
                    if (!btn_in) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == REP_LAST) begin
                        cnt_nxt = '0;
                        evt_nxt = EVT_REP;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                // A new press wins over the gap timeout landing on the same edge.
                ST_GAP: begin
                    if (btn_in) begin
                        state_nxt = ST_PRESS2;
                        cnt_nxt   = '0;
                    end else if (cnt == GAP_LAST) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                        evt_nxt   = EVT_SHORT;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_PRESS2: begin
                    if (!btn_in) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                        evt_nxt   = EVT_DBL;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            short_p <= 1'b0;
            long_p  <= 1'b0;
            rep_p   <= 1'b0;
            dbl_p   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            short_p <= (evt_nxt == EVT_SHORT);
            long_p  <= (evt_nxt == EVT_LONG);
            rep_p   <= (evt_nxt == EVT_REP);
            dbl_p   <= (evt_nxt == EVT_DBL);
            busy    <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed table-driven bench for button_press_classifier with small thresholds.
module tb_button_press_classifier;

    localparam int unsigned CNT_W      = 4;
    localparam int unsigned LONG_CNT   = 8;
    localparam int unsigned REPEAT_CNT = 4;
    localparam int unsigned GAP_CNT    = 6;

    // Expected output word: {busy, short_p, long_p, rep_p, dbl_p}
    localparam logic [4:0] O_IDLE  = 5'b00000;
    localparam logic [4:0] O_BUSY  = 5'b10000;
    localparam logic [4:0] O_SHORT = 5'b01000;
    localparam logic [4:0] O_LONG  = 5'b10100;
    localparam logic [4:0] O_REP   = 5'b10010;
    localparam logic [4:0] O_DBL   = 5'b00001;

    logic clk = 1'b0;
    logic rstn, en, btn_in;
    logic short_p, long_p, rep_p, dbl_p, busy;

    typedef struct {
        string      tag;
        logic       en;
        logic       btn;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    button_press_classifier #(
        .CNT_W      (CNT_W),
        .LONG_CNT   (LONG_CNT),
        .REPEAT_CNT (REPEAT_CNT),
        .GAP_CNT    (GAP_CNT)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .en      (en),
        .btn_in  (btn_in),
        .short_p (short_p),
        .long_p  (long_p),
        .rep_p   (rep_p),
        .dbl_p   (dbl_p),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {busy, short_p, long_p, rep_p, dbl_p};
    endfunction

    task automatic add(input string tag, input logic e, input logic b,
                       input logic [4:0] x, input int n);
        vec_t v;
        v.tag = tag;
        v.en  = e;
        v.btn = b;
        v.exp = x;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [4:0] exp);
        logic [4:0] act;
        act = outs();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: busy/short/long/rep/dbl got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic b);
        en     = e;
        btn_in = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Short press: 3 held, release; short_p 6 edges after release, busy drops with it
        add("short", 1, 1, O_BUSY, 3);
        add("short", 1, 0, O_BUSY, 6);
        add("short", 1, 0, O_SHORT, 1);
        add("short", 1, 0, O_IDLE, 2);
        // Long press with three repeats, then release without any pulse
        add("long", 1, 1, O_BUSY, 8);
        add("long", 1, 1, O_LONG, 1);
        for (int r = 0; r < 3; r++) begin
            add("long", 1, 1, O_BUSY, 3);
            add("long", 1, 1, O_REP, 1);
        end
        add("long_rel", 1, 0, O_IDLE, 8);
        // Double press; second press held past LONG_CNT yields no long_p
        add("dbl", 1, 1, O_BUSY, 2);
        add("dbl", 1, 0, O_BUSY, 3);
        add("dbl", 1, 1, O_BUSY, 10);
        add("dbl", 1, 0, O_DBL, 1);
        add("dbl", 1, 0, O_IDLE, 7);
        // Second press lands when gap cnt==GAP_CNT-1: still a double
        add("dbl_edge", 1, 1, O_BUSY, 2);
        add("dbl_edge", 1, 0, O_BUSY, 6);
        add("dbl_edge", 1, 1, O_BUSY, 2);
        add("dbl_edge", 1, 0, O_DBL, 1);
        add("dbl_edge", 1, 0, O_IDLE, 2);
        // One edge later the gap has timed out: short, then a fresh PRESS1 reaching long
        add("gap_to", 1, 1, O_BUSY, 2);
        add("gap_to", 1, 0, O_BUSY, 6);
        add("gap_to", 1, 0, O_SHORT, 1);
        add("gap_to", 1, 1, O_BUSY, 8);
        add("gap_to", 1, 1, O_LONG, 1);
        add("gap_to", 1, 0, O_IDLE, 2);
        // Single-cycle glitch counts as a short press
        add("glitch", 1, 1, O_BUSY, 1);
        add("glitch", 1, 0, O_BUSY, 6);
        add("glitch", 1, 0, O_SHORT, 1);
        add("glitch", 1, 0, O_IDLE, 1);
        // en dropped mid-LONG, then raised with the button still held
        add("en_long", 1, 1, O_BUSY, 8);
        add("en_long", 1, 1, O_LONG, 1);
        add("en_long", 1, 1, O_BUSY, 2);
        add("en_long", 0, 1, O_IDLE, 5);
        add("en_long", 1, 1, O_BUSY, 8);
        add("en_long", 1, 1, O_LONG, 1);
        add("en_long", 1, 1, O_BUSY, 3);
        add("en_long", 1, 1, O_REP, 1);
        add("en_long", 1, 0, O_IDLE, 1);
        // en dropped in GAP suppresses the pending short_p
        add("en_gap", 1, 1, O_BUSY, 1);
        add("en_gap", 1, 0, O_BUSY, 2);
        add("en_gap", 0, 0, O_IDLE, 2);
        add("en_gap", 1, 0, O_IDLE, 7);
        // en low blocks a new gesture from starting
        add("en_idle", 0, 1, O_IDLE, 3);
        add("en_idle", 1, 0, O_IDLE, 1);

        rstn   = 1'b0;
        en     = 1'b1;
        btn_in = 1'b0;
        #2;
        check("reset_initial", O_IDLE);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].btn);
            check($sformatf("%s[%0d]", vecs[i].tag, i), vecs[i].exp);
        end

        // Async reset while long_p is high; button held through reset release
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b1);
            check("rst_long_pre", O_BUSY);
        end
        step(1'b1, 1'b1);
        check("rst_long_pulse", O_LONG);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_async_clear", O_IDLE);
        @(negedge clk);
        check("rst_held", O_IDLE);
        rstn = 1'b1;
        step(1'b1, 1'b1);
        check("rst_press1_entry", O_BUSY);
        for (int k = 0; k < 7; k++) begin
            step(1'b1, 1'b1);
            check("rst_press1_hold", O_BUSY);
        end
        step(1'b1, 1'b1);
        check("rst_press1_long", O_LONG);
        step(1'b1, 1'b0);
        check("rst_press1_rel", O_IDLE);

        // Reset in GAP abandons the gesture: no stale short_p afterwards
        step(1'b1, 1'b1);
        check("rst_gap_press", O_BUSY);
        step(1'b1, 1'b0);
        check("rst_gap_rel", O_BUSY);
        step(1'b1, 1'b0);
        check("rst_gap_rel", O_BUSY);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_gap_clear", O_IDLE);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0);
            check("rst_no_stale", O_IDLE);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
